// File: rtl/man_drawer.sv
// Man sprite redraw engine: erases the old box, then draws the new one, one VGA pixel per cycle.
// Optional macro MAN_DRAWER_SPRITE_EN replaces the solid draw box with a 16x16 shape ROM.
module man_drawer #(
    parameter logic [7:0] MAN_X      = 8'd20,
    parameter int         MAN_W      = 8,
    parameter int         MAN_H      = 12,
    parameter logic [2:0] BG_COLOUR  = 3'b000,
    parameter logic [2:0] MAN_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic [6:0] y,
    input  logic       man_style,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

    localparam logic [3:0] LAST_COL = 4'(MAN_W - 1);
    localparam logic [3:0] LAST_ROW = 4'(MAN_H - 1);
    localparam logic [6:0] HOME_Y   = 7'd108;

    state_t     r_state, w_state;
    logic [3:0] r_col, r_row, w_col, w_row;
    logic       r_pending, r_drew;
    logic [6:0] r_old_y, r_new_y;
    logic [6:0] w_base;
    logic [7:0] w_row_sum;
    logic [8:0] w_col_sum;
    logic       w_start, w_in_scan, w_visible, w_shape;

    // Next-pixel view: outputs are registered from these so the pixel shows in the cycle it belongs to.
    always_comb begin
        w_state = r_state;
        w_col   = r_col;
        w_row   = r_row;
        w_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (update || r_pending) begin
                    w_state = S_ERASE;
                    w_col   = 4'd0;
                    w_row   = 4'd0;
                    w_start = 1'b1;
                end
            end
            S_ERASE, S_DRAW: begin
                if (r_col == LAST_COL) begin
                    w_col = 4'd0;
                    if (r_row == LAST_ROW) begin
                        w_row   = 4'd0;
                        w_state = (r_state == S_ERASE && man_style) ? S_DRAW : S_DONE;
                    end else begin
                        w_row = r_row + 4'd1;
                    end
                end else begin
                    w_col = r_col + 4'd1;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // Sums are kept one bit wider than the screen coordinate so clipping never sees a wrapped value.
    assign w_base    = (w_state == S_DRAW) ? r_new_y : r_old_y;
    assign w_row_sum = {1'b0, w_base} + {4'b0000, w_row};
    assign w_col_sum = {1'b0, MAN_X} + {5'b00000, w_col};
    assign w_in_scan = (w_state == S_ERASE) || (w_state == S_DRAW);
    assign w_visible = (w_row_sum < 8'd120) && (w_col_sum < 9'd160);

`ifdef MAN_DRAWER_SPRITE_EN
    function automatic logic [15:0] shape_row(input logic [3:0] row);
        case (row)
            4'd1, 4'd4:        shape_row = 16'h0018;
            4'd2, 4'd3, 4'd9:  shape_row = 16'h0024;
            4'd5:              shape_row = 16'h007E;
            4'd6, 4'd7, 4'd8:  shape_row = 16'h0018;
            4'd10, 4'd11:      shape_row = 16'h0042;
            default:           shape_row = 16'h0000;
        endcase
    endfunction

    logic [15:0] w_shape_bits;
    assign w_shape_bits = shape_row(w_row);
    // Erase always clears the full box; only the draw pass follows the shape.
    assign w_shape      = (w_state != S_DRAW) || w_shape_bits[w_col];
`else
    assign w_shape = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_col     <= 4'd0;
            r_row     <= 4'd0;
            r_pending <= 1'b0;
            r_drew    <= 1'b0;
            r_old_y   <= HOME_Y;
            r_new_y   <= HOME_Y;
            plot      <= 1'b0;
            vga_x     <= 8'd0;
            vga_y     <= 7'd0;
            colour    <= BG_COLOUR;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state <= w_state;
            r_col   <= w_col;
            r_row   <= w_row;
            if (w_start) begin
                r_new_y   <= y;
                r_pending <= 1'b0;
                r_drew    <= 1'b0;
            end else if (update && r_state != S_IDLE) begin
                r_pending <= 1'b1;
            end
            if (r_state == S_ERASE && w_state == S_DRAW)
                r_drew <= 1'b1;
            // A hidden man keeps old_y so a repeated erase hits the same spot.
            if (r_state == S_DONE && r_drew)
                r_old_y <= r_new_y;
            plot <= w_in_scan && w_visible && w_shape;
            if (w_in_scan) begin
                vga_x  <= w_col_sum[7:0];
                vga_y  <= w_row_sum[6:0];
                colour <= (w_state == S_DRAW) ? MAN_COLOUR : BG_COLOUR;
            end
            busy <= (w_state != S_IDLE);
            done <= (w_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_man_drawer.sv
// Scoreboard bench for man_drawer: a redraw-timeline model predicts every plot pixel and done pulse.
module tb_man_drawer;

    localparam int         MAN_X = 20;
    localparam int         MAN_W = 8;
    localparam int         MAN_H = 12;
    localparam int         N     = MAN_W * MAN_H;
    localparam logic [2:0] BG    = 3'b000;
    localparam logic [2:0] FG    = 3'b111;

    logic       clk = 1'b0;
    logic       reset, update, man_style;
    logic [6:0] y;
    logic       plot, busy, done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;

    man_drawer dut (
        .clk(clk), .reset(reset), .update(update), .y(y), .man_style(man_style),
        .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        int         x;
        int         y;
        logic [2:0] c;
    } px_t;

    px_t exp_q[$];
    int  done_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Redraw timeline: a redraw occupies cycles m_first..m_done inclusive.
    bit   m_active = 0, m_pending = 0, m_drew = 0;
    int   m_first = 0, m_done = 0;
    int   m_old_y = 108, m_new_y = 108;

    task automatic push_box(input int base, input logic [2:0] c, input int t0);
        for (int r = 0; r < MAN_H; r++)
            for (int k = 0; k < MAN_W; k++)
                if (base + r < 120 && MAN_X + k < 160)
                    exp_q.push_back('{t0 + r * MAN_W + k, MAN_X + k, base + r, c});
    endtask

    task automatic model(input bit upd, input logic [6:0] yy, input bit ms, input int k);
        if (m_active && k >= m_first) begin
            if (upd) m_pending = 1;
            if (k == m_first + N - 1) begin
                if (ms) begin
                    push_box(m_new_y, FG, k + 1);
                    m_drew = 1;
                    m_done = k + N + 1;
                end else begin
                    m_done = k + 1;
                end
                done_q.push_back(m_done);
            end
            if (k == m_done) begin
                if (m_drew) m_old_y = m_new_y;
                m_active = 0;
            end
        end else if (upd || m_pending) begin
            m_pending = 0;
            m_new_y   = int'(yy);
            m_drew    = 0;
            m_active  = 1;
            m_first   = k + 1;
            m_done    = 32'h7fffffff;
            push_box(m_old_y, BG, k + 1);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s t=%0d got %0d want %0d", name, cyc, got, want);
        end
    endtask

    task automatic step(input bit upd, input logic [6:0] yy, input bit ms);
        bit bexp;
        update    = upd;
        y         = yy;
        man_style = ms;
        bexp = m_active && cyc >= m_first;
        chk("busy", int'(busy), int'(bexp));
        model(upd, yy, ms, cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input logic [6:0] yy, input bit ms);
        int n;
        n = 0;
        while ((m_active || m_pending) && n < budget) begin
            step(1'b0, yy, ms);
            n++;
        end
        vectors++;
        if (m_active || m_pending) begin
            miscompares++;
            $display("FAIL idle_timeout t=%0d budget %0d exhausted", cyc, budget);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        update = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].t > cyc) void'(exp_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > cyc) void'(done_q.pop_back());
        m_active = 0; m_pending = 0; m_drew = 0;
        m_old_y = 108; m_new_y = 108;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_plot",   int'(plot),   0);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_done",   int'(done),   0);
        chk("rst_vga_x",  int'(vga_x),  0);
        chk("rst_vga_y",  int'(vga_y),  0);
        chk("rst_colour", int'(colour), int'(BG));
    endtask

    // Monitor: every plot/done strobe must match the head of its queue, including the cycle.
    always @(negedge clk) begin
        px_t e;
        int  d;
        if (plot === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL plot_unexpected t=%0d x=%0d y=%0d c=%0d none required", cyc, vga_x, vga_y, colour);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.x != int'(vga_x) || e.y != int'(vga_y) || e.c !== colour) begin
                    miscompares++;
                    $display("FAIL plot got t=%0d x=%0d y=%0d c=%0d want t=%0d x=%0d y=%0d c=%0d",
                             cyc, vga_x, vga_y, colour, e.t, e.x, e.y, e.c);
                end
            end
        end
        if (done === 1'b1) begin
            vectors++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected t=%0d none required", cyc);
            end else begin
                d = done_q.pop_front();
                if (d != cyc) begin
                    miscompares++;
                    $display("FAIL done got t=%0d want t=%0d", cyc, d);
                end
            end
        end
    end

    initial begin
        update = 1'b0; y = 7'd108; man_style = 1'b1; reset = 1'b1;
        do_reset();

        // Home position: full erase then full draw.
        step(1'b1, 7'd108, 1'b1);
        wait_idle(400, 7'd108, 1'b1);

        // Bottom-clipped box.
        step(1'b1, 7'd110, 1'b1);
        wait_idle(400, 7'd110, 1'b1);

        // Update mid-redraw queues a second redraw with the later y.
        step(1'b1, 7'd30, 1'b1);
        repeat (49) step(1'b0, 7'd30, 1'b1);
        step(1'b1, 7'd60, 1'b1);
        wait_idle(800, 7'd60, 1'b1);

        // Hidden man: erase only, twice at the same spot.
        step(1'b1, 7'd90, 1'b0);
        wait_idle(400, 7'd90, 1'b0);
        step(1'b1, 7'd10, 1'b0);
        wait_idle(400, 7'd10, 1'b0);

        // Reset at cycle 120 of a redraw, then a redraw erases at home.
        step(1'b1, 7'd40, 1'b1);
        repeat (119) step(1'b0, 7'd40, 1'b1);
        do_reset();
        repeat (20) step(1'b0, 7'd40, 1'b1);
        step(1'b1, 7'd50, 1'b1);
        wait_idle(400, 7'd50, 1'b1);

        // Random updates, positions and style changes.
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 59) == 0, 7'($urandom), $urandom_range(0, 3) != 0);
        wait_idle(1000, 7'd0, 1'b1);
        repeat (3) step(1'b0, 7'd0, 1'b1);

        chk("plots_drained", exp_q.size(), 0);
        chk("dones_drained", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
